// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with ripple incrementer.
// Holds under stall and buffers a redirect that arrives while stalled.
module pc_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter logic [WIDTH-1:0] STEP = WIDTH'(4),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             wrap,
  output logic             redirect_pending
);

  logic [WIDTH-1:0] pc_q;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_pc;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = 1'b0;

  // One full-adder cell per bit: a = pc, b = STEP, carry ripples upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic a;
    logic b;
    assign a            = pc_q[i];
    assign b            = STEP[i];
    assign sum[i]       = a ^ b ^ carry[i];
    assign carry[i+1]   = (a & b) | (carry[i] & (a ^ b));
  end

  assign pc               = pc_q;
  assign pc_plus_step     = sum;
  assign wrap             = carry[WIDTH];
  assign redirect_pending = pend_valid;

  // PC and redirect buffer update, in priority order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (stall) begin
      if (redirect) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      pend_valid <= 1'b0;
    end else if (pend_valid) begin
      pc_q       <= pend_pc;
      pend_valid <= 1'b0;
    end else begin
      pc_q <= sum;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer.
// Two instances: 64-bit default and 8-bit for wrap coverage.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, redirect;
  logic [63:0] redirect_pc;
  logic [63:0] pc, pps;
  logic        wrap, pend;

  logic        reset8, stall8, redirect8;
  logic [7:0]  redirect_pc8;
  logic [7:0]  pc8, pps8;
  logic        wrap8, pend8;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .pc_plus_step(pps), .wrap(wrap),
    .redirect_pending(pend)
  );

  pc_sequencer #(.WIDTH(8), .STEP(8'd4), .RESET_PC(8'h00)) dut8 (
    .clk(clk), .reset(reset8), .stall(stall8),
    .redirect(redirect8), .redirect_pc(redirect_pc8),
    .pc(pc8), .pc_plus_step(pps8), .wrap(wrap8),
    .redirect_pending(pend8)
  );

  int total = 0;
  int bad = 0;

  // Reference models: plain arithmetic on integers.
  logic [63:0] m_pc, m_ppc;
  bit          m_pend;
  int unsigned m8_pc, m8_ppc;
  bit          m8_pend;

  task automatic step(input bit r, input bit s, input bit rd,
                      input logic [63:0] t);
    reset = r; stall = s; redirect = rd; redirect_pc = t;
    @(posedge clk);
    if (r) begin
      m_pc = 64'd0; m_pend = 0; m_ppc = 64'd0;
    end else if (s) begin
      if (rd) begin m_pend = 1; m_ppc = t; end
    end else if (rd) begin
      m_pc = t; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_ppc; m_pend = 0;
    end else begin
      m_pc = m_pc + 64'd4;
    end
    #1;
  endtask

  task automatic step8(input bit r, input bit s, input bit rd,
                       input logic [7:0] t);
    reset8 = r; stall8 = s; redirect8 = rd; redirect_pc8 = t;
    @(posedge clk);
    if (r) begin
      m8_pc = 0; m8_pend = 0; m8_ppc = 0;
    end else if (s) begin
      if (rd) begin m8_pend = 1; m8_ppc = t; end
    end else if (rd) begin
      m8_pc = t; m8_pend = 0;
    end else if (m8_pend) begin
      m8_pc = m8_ppc; m8_pend = 0;
    end else begin
      m8_pc = (m8_pc + 4) % 256;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 64'd0);
    total++;
    if (pc !== 64'd0) begin
      bad++; $display("FAIL reset_pc got=%h exp=0", pc);
    end
    total++;
    if (pend !== 1'b0) begin
      bad++; $display("FAIL reset_pend got=%b exp=0", pend);
    end
    total++;
    if (pps !== 64'd4 || wrap !== 1'b0) begin
      bad++; $display("FAIL reset_pps got=%h/%b exp=4/0", pps, wrap);
    end
  endtask

  task automatic test_free_run;
    for (int i = 1; i <= 2; i++) begin
      step(0, 0, 0, 64'd0);
      total++;
      if (pc !== 64'(4 * i) || pend !== 1'b0 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL free_run got=%h/%b/%b exp=%h/0/0",
                 pc, pend, wrap, 64'(4 * i));
      end
    end
  endtask

  task automatic test_redirect;
    step(0, 0, 1, 64'h100);
    total++;
    if (pc !== 64'h100) begin
      bad++; $display("FAIL redirect got=%h exp=100", pc);
    end
    step(0, 0, 0, 64'h0);
    total++;
    if (pc !== 64'h104) begin
      bad++; $display("FAIL redirect_next got=%h exp=104", pc);
    end
  endtask

  task automatic test_stall_buffer;
    step(0, 1, 1, 64'h200);
    total++;
    if (pc !== 64'h104 || pend !== 1'b1) begin
      bad++; $display("FAIL stall1 got=%h/%b exp=104/1", pc, pend);
    end
    step(0, 1, 1, 64'h300);
    total++;
    if (pc !== 64'h104 || pend !== 1'b1) begin
      bad++; $display("FAIL stall2 got=%h/%b exp=104/1", pc, pend);
    end
    step(0, 1, 0, 64'h0);
    total++;
    if (pc !== 64'h104 || pend !== 1'b1) begin
      bad++; $display("FAIL stall3 got=%h/%b exp=104/1", pc, pend);
    end
    step(0, 0, 0, 64'h0);
    total++;
    if (pc !== 64'h300 || pend !== 1'b0) begin
      bad++; $display("FAIL unstall got=%h/%b exp=300/0", pc, pend);
    end
    step(0, 0, 0, 64'h0);
    total++;
    if (pc !== 64'h304) begin
      bad++; $display("FAIL unstall_next got=%h exp=304", pc);
    end
  endtask

  task automatic test_live_beats_buffered;
    step(0, 1, 1, 64'h200);
    step(0, 0, 1, 64'h400);
    total++;
    if (pc !== 64'h400 || pend !== 1'b0) begin
      bad++; $display("FAIL live_redirect got=%h/%b exp=400/0", pc, pend);
    end
    step(0, 0, 0, 64'h0);
    total++;
    if (pc !== 64'h404) begin
      bad++; $display("FAIL live_discard got=%h exp=404", pc);
    end
  endtask

  task automatic test_wrap;
    step8(1, 0, 0, 8'h0);
    step8(0, 0, 1, 8'hFC);
    total++;
    if (pc8 !== 8'hFC || pps8 !== 8'h00 || wrap8 !== 1'b1) begin
      bad++;
      $display("FAIL wrap got=%h/%h/%b exp=fc/00/1", pc8, pps8, wrap8);
    end
    step8(0, 0, 0, 8'h0);
    total++;
    if (pc8 !== 8'h00 || pps8 !== 8'h04 || wrap8 !== 1'b0) begin
      bad++;
      $display("FAIL wrap_next got=%h/%h/%b exp=00/04/0", pc8, pps8, wrap8);
    end
  endtask

  task automatic test_reset_mid;
    step(0, 1, 1, 64'h880);
    total++;
    if (pend !== 1'b1) begin
      bad++; $display("FAIL mid_pend got=%b exp=1", pend);
    end
    step(1, 1, 0, 64'h0);
    total++;
    if (pc !== 64'h0 || pend !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%h/%b exp=0/0", pc, pend);
    end
    step(0, 0, 0, 64'h0);
    total++;
    if (pc !== 64'h4) begin
      bad++; $display("FAIL mid_release got=%h exp=4", pc);
    end
  endtask

  task automatic test_random;
    logic [63:0] t;
    logic [64:0] s65;
    int unsigned s9;
    for (int i = 0; i < 400; i++) begin
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t = ~64'd0 - 64'($urandom_range(0, 7));
      fork
        step($urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, t);
        step8($urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0, 8'($urandom));
      join
      s65 = {1'b0, m_pc} + 65'd4;
      total++;
      if (pc !== m_pc || pend !== m_pend) begin
        bad++;
        $display("FAIL rand_pc got=%h/%b exp=%h/%b", pc, pend, m_pc, m_pend);
      end
      total++;
      if (pps !== s65[63:0] || wrap !== s65[64]) begin
        bad++;
        $display("FAIL rand_pps got=%h/%b exp=%h/%b",
                 pps, wrap, s65[63:0], s65[64]);
      end
      s9 = m8_pc + 4;
      total++;
      if (pc8 !== 8'(m8_pc) || pend8 !== m8_pend ||
          pps8 !== 8'(s9) || wrap8 !== (s9 > 255)) begin
        bad++;
        $display("FAIL rand8 got=%h/%b/%h/%b exp=%h/%b/%h/%b",
                 pc8, pend8, pps8, wrap8,
                 8'(m8_pc), m8_pend, 8'(s9), s9 > 255);
      end
    end
  endtask

  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_pc = '0;
    reset8 = 1; stall8 = 0; redirect8 = 0; redirect_pc8 = '0;
    m_pc = 0; m_ppc = 0; m_pend = 0;
    m8_pc = 0; m8_ppc = 0; m8_pend = 0;
    test_reset;
    test_free_run;
    test_redirect;
    test_stall_buffer;
    test_live_beats_buffered;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
